// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_timer_ctrl
//  Purpose  : Sequencing controller for the two-digit BCD level timer.
//             Loads the start value on level start and derives a 1 Hz count
//             strobe from the system clock. Also handles pause, freeze on
//             player death, expiry, and the end-of-level bonus tally (fast
//             drain of remaining seconds, one score pulse per second).
//  Ports    : clk, resetN (async, active-low)
//             level_start, pause_req, level_done, player_dead - game events
//             countL/countH/timer_tc     - timer value and terminal count
//             timer_loadN/timer_ena/timer_ena_cnt/timer_countDownMode
//                                         - timer control
//             time_up, bonus_pulse, tally_done - event pulses
//             warning                    - low-time indicator
//             state                      - FSM state (IDLE=0 .. EXPIRED=5)
//  Revision : 1.0 - initial release
// ============================================================================
module game_timer_ctrl #(
  parameter int CLK_HZ    = 25_000_000,
  parameter int TALLY_DIV = 250_000,
  parameter int WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       level_start,
  input  logic       pause_req,
  input  logic       level_done,
  input  logic       player_dead,
  input  logic [3:0] countL,
  input  logic [3:0] countH,
  input  logic       timer_tc,
  output logic       timer_loadN,
  output logic       timer_ena,
  output logic       timer_ena_cnt,
  output logic       timer_countDownMode,
  output logic       time_up,
  output logic       bonus_pulse,
  output logic       tally_done,
  output logic       warning,
  output logic [2:0] state
);

  localparam int c_max_div = (CLK_HZ > TALLY_DIV) ? CLK_HZ : TALLY_DIV;
  localparam int c_presc_w = (c_max_div > 1) ? $clog2(c_max_div) : 1;
  localparam logic [c_presc_w-1:0] c_run_last   = c_presc_w'(CLK_HZ - 1);
  localparam logic [c_presc_w-1:0] c_tally_last = c_presc_w'(TALLY_DIV - 1);
  localparam logic [6:0]           c_warn       = 7'(WARN_SEC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_TALLY   = 3'd4,
    S_EXPIRED = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [c_presc_w-1:0]   r_presc;
  logic [c_presc_w-1:0]   w_presc_next;
  logic                   r_time_up;
  logic                   r_tally_done;
  logic                   w_run_due;
  logic                   w_tally_due;
  logic [6:0]             w_value;

  // A step is "due" on the last prescaler count of the current period.
  assign w_run_due   = (r_state == S_RUN)   && (r_presc == c_run_last);
  assign w_tally_due = (r_state == S_TALLY) && (r_presc == c_tally_last);

  // Next-state logic. level_start overrides everything; within RUN/PAUSE the
  // order player_dead > level_done > timer_tc > pause_req applies.
  always_comb begin
    w_next_state = r_state;
    if (level_start) begin
      w_next_state = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:    w_next_state = S_IDLE;
        S_LOAD:    w_next_state = S_RUN;
        S_RUN: begin
          if (player_dead)     w_next_state = S_IDLE;
          else if (level_done) w_next_state = S_TALLY;
          else if (timer_tc)   w_next_state = S_EXPIRED;
          else if (pause_req)  w_next_state = S_PAUSE;
        end
        S_PAUSE: begin
          if (player_dead)     w_next_state = S_IDLE;
          else if (level_done) w_next_state = S_TALLY;
          else if (!pause_req) w_next_state = S_RUN;
        end
        S_TALLY: begin
          if (w_tally_due && timer_tc) w_next_state = S_IDLE;
        end
        S_EXPIRED: w_next_state = S_EXPIRED;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Prescaler: counts while the current state is RUN (also on the cycle that
  // leaves for PAUSE), holds through PAUSE so a resume finishes the partial
  // second, and runs at the tally rate inside TALLY. Every other path,
  // including entry into RUN from LOAD and entry into TALLY, clears it.
  always_comb begin
    w_presc_next = '0;
    if (r_state == S_RUN && (w_next_state == S_RUN || w_next_state == S_PAUSE))
      w_presc_next = w_run_due ? '0 : r_presc + 1'b1;
    else if (r_state == S_PAUSE && (w_next_state == S_RUN || w_next_state == S_PAUSE))
      w_presc_next = r_presc;
    else if (r_state == S_TALLY && w_next_state == S_TALLY)
      w_presc_next = w_tally_due ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_time_up    <= 1'b0;
      r_tally_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_presc      <= w_presc_next;
      r_time_up    <= (w_next_state == S_EXPIRED) && (r_state != S_EXPIRED);
      r_tally_done <= (r_state == S_TALLY) && (w_next_state == S_IDLE);
    end
  end

  // Timer value in binary for the low-time comparison.
  assign w_value = ({3'b000, countH} * 7'd10) + {3'b000, countL};

  assign timer_loadN         = (r_state != S_LOAD);
  assign timer_ena           = (r_state != S_IDLE);
  assign timer_countDownMode = 1'b1;
  // Strobes are gated by timer_tc so the counter never wraps past 00.
  assign timer_ena_cnt       = (w_run_due || w_tally_due) && !timer_tc;
  assign bonus_pulse         = w_tally_due && !timer_tc;
  assign time_up             = r_time_up;
  assign tally_done          = r_tally_done;
  assign warning             = ((r_state == S_RUN) || (r_state == S_PAUSE)) &&
                               (w_value != 7'd0) && (w_value < c_warn);
  assign state               = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_timer_ctrl
//  Purpose  : Self-checking bench for game_timer_ctrl. A behavioural BCD
//             timer sits around the DUT, a reference model predicts all
//             outputs each cycle, and directed scenarios pin key timings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int TALLY_DIV = 3;
  localparam int WARN_SEC  = 10;
  localparam int IDLE = 0, LOAD = 1, RUN = 2, PAUSE = 3, TALLY = 4, EXPIRED = 5;

  logic       clk = 1'b0;
  logic       resetN;
  logic       level_start = 1'b0;
  logic       pause_req   = 1'b0;
  logic       level_done  = 1'b0;
  logic       player_dead = 1'b0;
  logic [3:0] countL;
  logic [3:0] countH;
  logic       timer_tc;
  logic       timer_loadN, timer_ena, timer_ena_cnt, timer_countDownMode;
  logic       time_up, bonus_pulse, tally_done, warning;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural timer (environment): value 0..99, loads/decrements on posedge.
  int count_val = 0;
  int n_count   = 0;
  int load_val  = 12;

  // Reference model: level phase and ticks elapsed in the current period.
  int m_state      = IDLE;
  int m_tick       = 0;
  bit m_time_up    = 1'b0;
  bit m_tally_done = 1'b0;

  always #5 clk = ~clk;

  assign countL   = 4'(count_val % 10);
  assign countH   = 4'(count_val / 10);
  assign timer_tc = (count_val == 0);

  game_timer_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .TALLY_DIV(TALLY_DIV),
    .WARN_SEC (WARN_SEC)
  ) dut (
    .clk                (clk),
    .resetN             (resetN),
    .level_start        (level_start),
    .pause_req          (pause_req),
    .level_done         (level_done),
    .player_dead        (player_dead),
    .countL             (countL),
    .countH             (countH),
    .timer_tc           (timer_tc),
    .timer_loadN        (timer_loadN),
    .timer_ena          (timer_ena),
    .timer_ena_cnt      (timer_ena_cnt),
    .timer_countDownMode(timer_countDownMode),
    .time_up            (time_up),
    .bonus_pulse        (bonus_pulse),
    .tally_done         (tally_done),
    .warning            (warning),
    .state              (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: predicts this cycle's outputs, checks them, then
  // advances the model and the environment timer for the coming edge.
  always @(negedge clk) begin
    int val, nxt, ntick;
    bit tc, due, active;
    val = count_val;
    tc  = (val == 0);
    if (!resetN) begin
      m_state = IDLE; m_tick = 0; m_time_up = 1'b0; m_tally_done = 1'b0;
    end
    due    = (m_state == RUN   && m_tick == CLK_HZ - 1) ||
             (m_state == TALLY && m_tick == TALLY_DIV - 1);
    active = (m_state == RUN) || (m_state == PAUSE);

    chk("state",       int'(state),               m_state);
    chk("loadN",       int'(timer_loadN),         (m_state == LOAD) ? 0 : 1);
    chk("ena",         int'(timer_ena),           (m_state == IDLE) ? 0 : 1);
    chk("ena_cnt",     int'(timer_ena_cnt),       (due && !tc) ? 1 : 0);
    chk("bonus_pulse", int'(bonus_pulse),         (m_state == TALLY && due && !tc) ? 1 : 0);
    chk("countdown",   int'(timer_countDownMode), 1);
    chk("time_up",     int'(time_up),             int'(m_time_up));
    chk("tally_done",  int'(tally_done),          int'(m_tally_done));
    chk("warning",     int'(warning),             (active && val > 0 && val < WARN_SEC) ? 1 : 0);

    nxt = m_state;
    if (!resetN)                        nxt = IDLE;
    else if (level_start)               nxt = LOAD;
    else if (active && player_dead)     nxt = IDLE;
    else if (active && level_done)      nxt = TALLY;
    else if (m_state == RUN && tc)      nxt = EXPIRED;
    else if (m_state == RUN && pause_req)    nxt = PAUSE;
    else if (m_state == PAUSE && !pause_req) nxt = RUN;
    else if (m_state == LOAD)           nxt = RUN;
    else if (m_state == TALLY && due && tc)  nxt = IDLE;

    if (nxt == IDLE || nxt == LOAD || nxt == EXPIRED)          ntick = 0;
    else if (nxt != m_state && (nxt == TALLY || m_state == LOAD)) ntick = 0;
    else if (m_state == RUN)                                   ntick = (m_tick + 1) % CLK_HZ;
    else if (m_state == TALLY)                                 ntick = (m_tick + 1) % TALLY_DIV;
    else                                                       ntick = m_tick;

    m_time_up    = resetN && (nxt == EXPIRED) && (m_state != EXPIRED);
    m_tally_done = resetN && (m_state == TALLY) && (nxt == IDLE);
    m_state      = nxt;
    m_tick       = ntick;

    if (timer_ena && !timer_loadN)                       n_count = load_val;
    else if (timer_ena && timer_ena_cnt && count_val > 0) n_count = count_val - 1;
    else                                                 n_count = count_val;
  end

  always @(posedge clk) count_val <= n_count;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int v, input int limit, input string name);
    int k;
    k = 0;
    while (count_val != v && k < limit) begin
      cyc(1);
      k++;
    end
    chk(name, count_val, v);
  endtask

  task automatic start_level(input int v);
    load_val    = v;
    level_start = 1'b1;
    cyc(1);
    level_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, last, nstrobe, warn_val, s, nb, lastb, r;
    resetN = 1'b1;
    #2 resetN = 1'b0;
    cyc(3);
    chk("rst_state", int'(state), 0);
    chk("rst_loadN", int'(timer_loadN), 1);
    chk("rst_ena",   int'(timer_ena), 0);
    resetN = 1'b1;
    cyc(2);

    // Full run from 12 to expiry.
    start_level(12);
    chk("load_state", int'(state), LOAD);
    chk("load_loadN", int'(timer_loadN), 0);
    cyc(1);
    chk("run_entry_state", int'(state), RUN);
    chk("run_loaded", count_val, 12);
    k = 0; last = -1; nstrobe = 0; warn_val = -1;
    while (!time_up && k < 300) begin
      if (timer_ena_cnt) begin
        nstrobe++;
        if (last >= 0) chk("strobe_gap", k - last, CLK_HZ);
        else           chk("first_strobe", k + 1, CLK_HZ);
        last = k;
      end
      if (warning && warn_val < 0) warn_val = count_val;
      cyc(1);
      k++;
    end
    chk("time_up_latency", k, 12 * CLK_HZ + 1);
    chk("strobe_total", nstrobe, 12);
    chk("warning_rise_value", warn_val, 9);
    chk("expired_state", int'(state), EXPIRED);
    cyc(1);
    chk("time_up_single", int'(time_up), 0);
    cyc(4);
    chk("expired_holds", int'(state), EXPIRED);

    // Pause mid-second at 05 for 37 cycles.
    start_level(12);
    cyc(1);
    wait_count(5, 200, "reach_05");
    cyc(3);
    pause_req = 1'b1;
    s = 0;
    for (int i = 0; i < 37; i++) begin
      cyc(1);
      if (timer_ena_cnt) s++;
    end
    chk("pause_no_strobe", s, 0);
    chk("pause_state", int'(state), PAUSE);
    pause_req = 1'b0;
    k = 0;
    while (!timer_ena_cnt && k < 30) begin
      cyc(1);
      k++;
    end
    chk("resume_distance", k, CLK_HZ - 4);
    chk("resume_count", count_val, 5);

    // Tally from 04.
    wait_count(4, 200, "reach_04");
    level_done = 1'b1;
    cyc(1);
    level_done = 1'b0;
    chk("tally_state", int'(state), TALLY);
    k = 0; nb = 0; lastb = -1;
    while (!tally_done && k < 60) begin
      if (bonus_pulse) begin
        nb++;
        chk("bonus_with_cnt", int'(timer_ena_cnt), 1);
        if (lastb >= 0) chk("bonus_gap", k - lastb, TALLY_DIV);
        lastb = k;
      end
      cyc(1);
      k++;
    end
    chk("bonus_total", nb, 4);
    chk("tally_done_latency", k, 5 * TALLY_DIV);
    chk("tally_end_state", int'(state), IDLE);
    chk("tally_end_count", count_val, 0);
    cyc(1);
    chk("tally_done_single", int'(tally_done), 0);

    // Load 00: level_done on first RUN cycle beats timer_tc -> empty tally.
    start_level(0);
    cyc(1);
    level_done = 1'b1;
    cyc(1);
    level_done = 1'b0;
    chk("zero_tally_state", int'(state), TALLY);
    k = 0; nb = 0;
    while (!tally_done && k < 20) begin
      if (bonus_pulse) nb++;
      cyc(1);
      k++;
    end
    chk("zero_tally_latency", k, TALLY_DIV);
    chk("zero_tally_bonus", nb, 0);

    // Load 00 with no events: time_up on 2nd cycle after LOAD.
    start_level(0);
    cyc(2);
    chk("zero_load_time_up", int'(time_up), 1);

    // Simultaneous level_start and player_dead in RUN.
    start_level(12);
    cyc(3);
    level_start = 1'b1;
    player_dead = 1'b1;
    cyc(1);
    level_start = 1'b0;
    player_dead = 1'b0;
    chk("start_beats_dead", int'(state), LOAD);

    // Death at 08 freezes the timer.
    cyc(1);
    wait_count(8, 200, "reach_08");
    player_dead = 1'b1;
    cyc(1);
    player_dead = 1'b0;
    chk("dead_state", int'(state), IDLE);
    chk("dead_ena", int'(timer_ena), 0);
    cyc(20);
    chk("dead_frozen", count_val, 8);

    // Asynchronous reset during RUN at 07.
    start_level(12);
    cyc(1);
    wait_count(7, 200, "reach_07");
    resetN = 1'b0;
    #1;
    chk("arst_state",   int'(state), 0);
    chk("arst_loadN",   int'(timer_loadN), 1);
    chk("arst_ena",     int'(timer_ena), 0);
    chk("arst_ena_cnt", int'(timer_ena_cnt), 0);
    chk("arst_warning", int'(warning), 0);
    chk("arst_time_up", int'(time_up), 0);
    cyc(3);
    chk("arst_hold_state", int'(state), 0);
    resetN = 1'b1;
    cyc(2);
    chk("arst_release_state", int'(state), 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      level_start = (r < 2);
      player_dead = (r >= 2 && r < 3);
      level_done  = (r >= 3 && r < 5);
      if ($urandom_range(0, 19) == 0) pause_req = ~pause_req;
      if (level_start) begin
        if ($urandom_range(0, 3) == 0) load_val = int'($urandom_range(0, 99));
        else                           load_val = int'($urandom_range(0, 15));
      end
      if (!resetN)                            resetN = 1'b1;
      else if ($urandom_range(0, 499) == 0)   resetN = 1'b0;
      cyc(1);
    end
    level_start = 1'b0;
    player_dead = 1'b0;
    level_done  = 1'b0;
    pause_req   = 1'b0;
    resetN      = 1'b1;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
